// File: rtl/cdb_pkg.sv
// Shared completion-bus definitions: source indices, result entry layout and
// round-robin pointer helper used by the CDB arbiter, ROB and execution units.
package cdb_pkg;

  localparam int unsigned SRC_ALU = 0;
  localparam int unsigned SRC_MUL = 1;
  localparam int unsigned SRC_DIV = 2;
  localparam int unsigned SRC_BR  = 3;
  localparam int unsigned SRC_LS  = 4;

  localparam int unsigned CDB_MAX_SRC = 8;
  localparam int unsigned CDB_SRC_W   = 3;
  localparam int unsigned CDB_DATA_W  = 32;
  localparam int unsigned CDB_TAG_W   = 32;

  typedef struct packed {
    logic                  exc;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] value;
  } cdb_entry_t;

  function automatic logic [CDB_SRC_W-1:0] rr_next(input logic [CDB_SRC_W-1:0] cur,
                                                   input int unsigned num_src);
    if (32'(cur) + 1 >= num_src) return '0;
    return cur + 1'b1;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result queue: power-of-two depth, flushable, with ready derived
// only from the registered count so grant never feeds back into ready.
module cdb_src_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 65,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cdb_src_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign ready   = (count != CNT_W'(DEPTH));
  assign do_push = push && ready && !flush;
  assign do_pop  = pop && (count != '0) && !flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Serializes completed results from the execution units onto a single
// registered, flushable CDB write port using round-robin arbitration.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned NUM_SRC = 5,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TAG_W   = 32,
  parameter int unsigned DEPTH   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        in_valid,
  output logic [NUM_SRC-1:0]        in_ready,
  input  logic [NUM_SRC*DATA_W-1:0] in_value,
  input  logic [NUM_SRC*TAG_W-1:0]  in_tag,
  input  logic [NUM_SRC-1:0]        in_exc,
  input  logic                      cdb_stall,
  output logic                      cdb_valid,
  output logic [DATA_W-1:0]         cdb_value,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic                      cdb_exc,
  output logic [CDB_SRC_W-1:0]      cdb_src,
  output logic [NUM_SRC*2-1:0]      occupancy
);

  localparam int unsigned ENT_W = 1 + TAG_W + DATA_W;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  if (NUM_SRC == 0 || NUM_SRC > CDB_MAX_SRC) begin : g_bad_num_src
    $error("cdb_arbiter: NUM_SRC must be 1..8 to fit the 3-bit cdb_src");
  end
  if (CNT_W > 2) begin : g_bad_depth
    $error("cdb_arbiter: DEPTH too large for the 2-bit per-source occupancy field");
  end

  logic [NUM_SRC-1:0]     eligible;
  logic [NUM_SRC-1:0]     pop;
  logic [ENT_W-1:0]       heads  [NUM_SRC];
  logic [CNT_W-1:0]       counts [NUM_SRC];
  logic [CDB_MAX_SRC-1:0] eligible_ext;
  logic [CDB_SRC_W-1:0]   rr_ptr;
  logic [CDB_SRC_W-1:0]   grant_idx;
  logic [CDB_SRC_W-1:0]   scan_idx;
  logic                   grant_found;
  logic [ENT_W-1:0]       grant_entry;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    cdb_src_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (in_valid[s]),
      .pop   (pop[s]),
      .wdata ({in_exc[s], in_tag[s*TAG_W +: TAG_W], in_value[s*DATA_W +: DATA_W]}),
      .rdata (heads[s]),
      .count (counts[s]),
      .ready (in_ready[s])
    );

    assign eligible[s]           = (counts[s] != '0);
    assign pop[s]                = grant_found && (grant_idx == CDB_SRC_W'(s));
    assign occupancy[s*2 +: 2]   = 2'(counts[s]);
  end

  // Index into a zero-padded 8-wide vector so the 3-bit scan index is legal for any NUM_SRC.
  always_comb begin
    eligible_ext                = '0;
    eligible_ext[NUM_SRC-1:0]   = eligible;
    grant_found                 = 1'b0;
    grant_idx                   = '0;
    scan_idx                    = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      scan_idx = CDB_SRC_W'((32'(rr_ptr) + i) % NUM_SRC);
      if (!grant_found && eligible_ext[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
    if (cdb_stall || flush) grant_found = 1'b0;
  end

  always_comb begin
    grant_entry = '0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      if (grant_idx == CDB_SRC_W'(s)) grant_entry = heads[s];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_value <= '0;
      cdb_tag   <= '0;
      cdb_exc   <= 1'b0;
      cdb_src   <= '0;
    end else if (grant_found) begin
      rr_ptr    <= rr_next(grant_idx, NUM_SRC);
      cdb_valid <= 1'b1;
      cdb_value <= grant_entry[DATA_W-1:0];
      cdb_tag   <= grant_entry[DATA_W +: TAG_W];
      cdb_exc   <= grant_entry[ENT_W-1];
      cdb_src   <= grant_idx;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter: reset, single source, round-robin order,
// backpressure, flush and simultaneous push/pop with exception passthrough.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic         clk;
  logic         rst;
  logic         flush;
  logic [4:0]   in_valid;
  logic [4:0]   in_ready;
  logic [159:0] in_value;
  logic [159:0] in_tag;
  logic [4:0]   in_exc;
  logic         cdb_stall;
  logic         cdb_valid;
  logic [31:0]  cdb_value;
  logic [31:0]  cdb_tag;
  logic         cdb_exc;
  logic [2:0]   cdb_src;
  logic [9:0]   occupancy;

  int unsigned errors;
  int unsigned checks;

  cdb_arbiter #(
    .NUM_SRC (5),
    .DATA_W  (32),
    .TAG_W   (32),
    .DEPTH   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_tag    (in_tag),
    .in_exc    (in_exc),
    .cdb_stall (cdb_stall),
    .cdb_valid (cdb_valid),
    .cdb_value (cdb_value),
    .cdb_tag   (cdb_tag),
    .cdb_exc   (cdb_exc),
    .cdb_src   (cdb_src),
    .occupancy (occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    in_valid = '0;
    in_value = '0;
    in_tag   = '0;
    in_exc   = '0;
  endtask

  task automatic push(input int unsigned s, input logic [31:0] v, input logic [31:0] t,
                      input logic e);
    in_valid[s]         = 1'b1;
    in_value[s*32 +: 32] = v;
    in_tag[s*32 +: 32]   = t;
    in_exc[s]           = e;
  endtask

  task automatic test_reset;
    clear_inputs();
    push(SRC_ALU, 32'h1, 32'h1, 1'b0);
    tick();
    push(SRC_ALU, 32'h2, 32'h2, 1'b0);
    tick();
    clear_inputs();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_value !== 32'h1) begin
      errors++;
      $display("FAIL reset_pre_bcast: valid=%0b value=%h want valid=1 value=1", cdb_valid, cdb_value);
    end
    checks++;
    if (occupancy !== 10'h001) begin
      errors++;
      $display("FAIL reset_pre_occ: got %h want 001", occupancy);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (cdb_valid !== 1'b0 || cdb_value !== 32'h0) begin
      errors++;
      $display("FAIL reset_async_cdb: valid=%0b value=%h want 0/0", cdb_valid, cdb_value);
    end
    checks++;
    if (in_ready !== 5'b11111) begin
      errors++;
      $display("FAIL reset_async_ready: got %b want 11111", in_ready);
    end
    checks++;
    if (occupancy !== 10'h000) begin
      errors++;
      $display("FAIL reset_async_occ: got %h want 000", occupancy);
    end
    #1 rst = 1'b0;
    tick();
  endtask

  task automatic test_single;
    push(SRC_ALU, 32'h0000_00AA, 32'h0000_0010, 1'b0);
    tick();
    clear_inputs();
    checks++;
    if (cdb_valid !== 1'b0 || occupancy !== 10'h001) begin
      errors++;
      $display("FAIL single_no_bypass: valid=%0b occ=%h want 0/001", cdb_valid, occupancy);
    end
    tick();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_value !== 32'hAA || cdb_tag !== 32'h10 ||
        cdb_src !== 3'd0 || cdb_exc !== 1'b0) begin
      errors++;
      $display("FAIL single_bcast: valid=%0b value=%h tag=%h src=%0d exc=%0b want 1/aa/10/0/0",
               cdb_valid, cdb_value, cdb_tag, cdb_src, cdb_exc);
    end
    tick();
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse: valid=%0b want 0", cdb_valid);
    end
  endtask

  task automatic test_round_robin;
    int unsigned exp;
    // Grant LS alone so the pointer wraps to 0.
    push(SRC_LS, 32'h0, 32'h0, 1'b0);
    tick();
    clear_inputs();
    tick();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_src !== 3'd4) begin
      errors++;
      $display("FAIL rr_prep_ls: valid=%0b src=%0d want 1/4", cdb_valid, cdb_src);
    end
    tick();
    for (int unsigned s = 0; s < 5; s++) push(s, 32'h0, 32'h20 + s, 1'b0);
    tick();
    clear_inputs();
    for (int unsigned k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (cdb_valid !== 1'b1 || cdb_src !== 3'(k) || cdb_tag !== 32'h20 + k) begin
        errors++;
        $display("FAIL rr0_grant%0d: valid=%0b src=%0d tag=%h want 1/%0d/%h",
                 k, cdb_valid, cdb_src, cdb_tag, k, 32'h20 + k);
      end
    end
    tick();
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr0_idle: valid=%0b want 0", cdb_valid);
    end
    // Grant DIV alone so the pointer moves to 3.
    push(SRC_DIV, 32'h0, 32'h0, 1'b0);
    tick();
    clear_inputs();
    tick();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_src !== 3'd2) begin
      errors++;
      $display("FAIL rr_prep_div: valid=%0b src=%0d want 1/2", cdb_valid, cdb_src);
    end
    tick();
    for (int unsigned s = 0; s < 5; s++) push(s, 32'h0, 32'h40 + s, 1'b0);
    tick();
    clear_inputs();
    for (int unsigned k = 0; k < 5; k++) begin
      exp = (3 + k) % 5;
      tick();
      checks++;
      if (cdb_valid !== 1'b1 || cdb_src !== 3'(exp) || cdb_tag !== 32'h40 + exp) begin
        errors++;
        $display("FAIL rr3_grant%0d: valid=%0b src=%0d tag=%h want 1/%0d/%h",
                 k, cdb_valid, cdb_src, cdb_tag, exp, 32'h40 + exp);
      end
    end
    tick();
    checks++;
    if (cdb_valid !== 1'b0 || occupancy !== 10'h000) begin
      errors++;
      $display("FAIL rr3_idle: valid=%0b occ=%h want 0/000", cdb_valid, occupancy);
    end
  endtask

  task automatic test_backpressure;
    cdb_stall = 1'b1;
    push(SRC_DIV, 32'h0, 32'h100, 1'b0);
    tick();
    push(SRC_DIV, 32'h0, 32'h104, 1'b0);
    tick();
    checks++;
    if (in_ready[SRC_DIV] !== 1'b0 || occupancy[5:4] !== 2'd2 || cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: ready=%0b occ=%0d valid=%0b want 0/2/0",
               in_ready[SRC_DIV], occupancy[5:4], cdb_valid);
    end
    push(SRC_DIV, 32'h0, 32'h108, 1'b0);
    tick();
    checks++;
    if (occupancy[5:4] !== 2'd2 || cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: occ=%0d valid=%0b want 2/0", occupancy[5:4], cdb_valid);
    end
    cdb_stall = 1'b0;
    #1;
    checks++;
    if (in_ready[SRC_DIV] !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_registered: ready=%0b want 0", in_ready[SRC_DIV]);
    end
    tick();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 32'h100 || occupancy[5:4] !== 2'd1) begin
      errors++;
      $display("FAIL bp_out0: valid=%0b tag=%h occ=%0d want 1/100/1", cdb_valid, cdb_tag, occupancy[5:4]);
    end
    tick();
    clear_inputs();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 32'h104 || occupancy[5:4] !== 2'd1) begin
      errors++;
      $display("FAIL bp_out1: valid=%0b tag=%h occ=%0d want 1/104/1", cdb_valid, cdb_tag, occupancy[5:4]);
    end
    tick();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 32'h108 || cdb_src !== 3'd2) begin
      errors++;
      $display("FAIL bp_out2: valid=%0b tag=%h src=%0d want 1/108/2", cdb_valid, cdb_tag, cdb_src);
    end
    tick();
    checks++;
    if (cdb_valid !== 1'b0 || occupancy !== 10'h000) begin
      errors++;
      $display("FAIL bp_drain: valid=%0b occ=%h want 0/000", cdb_valid, occupancy);
    end
  endtask

  task automatic test_flush;
    cdb_stall = 1'b1;
    push(SRC_LS, 32'h0, 32'h300, 1'b0);
    push(SRC_MUL, 32'h0, 32'h310, 1'b0);
    tick();
    clear_inputs();
    push(SRC_LS, 32'h0, 32'h301, 1'b0);
    tick();
    clear_inputs();
    checks++;
    if (occupancy !== 10'h204) begin
      errors++;
      $display("FAIL flush_queued: occ=%h want 204", occupancy);
    end
    flush     = 1'b1;
    cdb_stall = 1'b0;
    push(SRC_BR, 32'h0, 32'h320, 1'b0);
    tick();
    flush = 1'b0;
    clear_inputs();
    checks++;
    if (occupancy !== 10'h000 || cdb_valid !== 1'b0 || in_ready !== 5'b11111) begin
      errors++;
      $display("FAIL flush_clear: occ=%h valid=%0b ready=%b want 000/0/11111",
               occupancy, cdb_valid, in_ready);
    end
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (cdb_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_no_bcast%0d: valid=%0b tag=%h want 0", k, cdb_valid, cdb_tag);
      end
    end
    // Pointer sits at 3 from the DIV grants; flush must not have moved it.
    push(SRC_ALU, 32'h0, 32'h330, 1'b0);
    push(SRC_BR, 32'h0, 32'h333, 1'b0);
    tick();
    clear_inputs();
    tick();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_src !== 3'd3 || cdb_tag !== 32'h333) begin
      errors++;
      $display("FAIL flush_rr_kept0: valid=%0b src=%0d tag=%h want 1/3/333", cdb_valid, cdb_src, cdb_tag);
    end
    tick();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_src !== 3'd0 || cdb_tag !== 32'h330) begin
      errors++;
      $display("FAIL flush_rr_kept1: valid=%0b src=%0d tag=%h want 1/0/330", cdb_valid, cdb_src, cdb_tag);
    end
    tick();
  endtask

  task automatic test_exc_push_pop;
    cdb_stall = 1'b1;
    push(SRC_LS, 32'h55, 32'h200, 1'b1);
    tick();
    clear_inputs();
    cdb_stall = 1'b0;
    push(SRC_LS, 32'h66, 32'h204, 1'b0);
    tick();
    clear_inputs();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_exc !== 1'b1 || cdb_tag !== 32'h200 ||
        cdb_value !== 32'h55 || cdb_src !== 3'd4) begin
      errors++;
      $display("FAIL exc_bcast: valid=%0b exc=%0b tag=%h value=%h src=%0d want 1/1/200/55/4",
               cdb_valid, cdb_exc, cdb_tag, cdb_value, cdb_src);
    end
    checks++;
    if (occupancy !== 10'h100) begin
      errors++;
      $display("FAIL exc_occ_same: occ=%h want 100", occupancy);
    end
    tick();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_exc !== 1'b0 || cdb_tag !== 32'h204 || cdb_value !== 32'h66) begin
      errors++;
      $display("FAIL exc_second: valid=%0b exc=%0b tag=%h value=%h want 1/0/204/66",
               cdb_valid, cdb_exc, cdb_tag, cdb_value);
    end
    tick();
    checks++;
    if (cdb_valid !== 1'b0 || occupancy !== 10'h000) begin
      errors++;
      $display("FAIL exc_drain: valid=%0b occ=%h want 0/000", cdb_valid, occupancy);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    cdb_stall = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_exc_push_pop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
